// File: rtl/cdb_arbiter.sv
// cdb_arbiter: two tagged-result FIFOs (ALU, memory unit) drained round-robin
// onto one registered common-data-bus broadcast slot. Provides registered
// stall back-pressure per producer, a sticky overflow flag and a full flush.
module cdb_arbiter #(
  parameter int DEPTH  = 4,
  parameter int TAG_W  = 3,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [TAG_W-1:0]  alu_des,
  input  logic [DATA_W-1:0] alu_data,
  input  logic [TAG_W-1:0]  mem_des,
  input  logic [DATA_W-1:0] mem_data,
  output logic              alu_stall,
  output logic              mem_stall,
  output logic [TAG_W-1:0]  cdb_des,
  output logic [DATA_W-1:0] cdb_data,
  output logic              cdb_src,
  output logic              overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
  // One slot of slack is kept for a result already launched when stall rises.
  localparam logic [CNT_W-1:0] STALL_CNT = CNT_W'(DEPTH - 1);

  // Source index 0 is the ALU, 1 is the memory unit; cdb_src uses the same code.
  logic [TAG_W-1:0]  in_tag_p0 [2];
  logic [DATA_W-1:0] in_dat_p0 [2];

  logic [TAG_W-1:0]  tag_mem [2][DEPTH];
  logic [DATA_W-1:0] dat_mem [2][DEPTH];
  logic [PTR_W-1:0]  wptr    [2];
  logic [PTR_W-1:0]  rptr    [2];
  logic [CNT_W-1:0]  cnt     [2];
  logic [CNT_W-1:0]  cnt_nxt [2];

  logic [1:0] not_empty;
  logic [1:0] full;
  logic [1:0] push_req;
  logic [1:0] push;
  logic [1:0] grant;
  logic [1:0] drop;

  // 1 = memory was granted last, so the ALU wins the next tie.
  logic last_grant;

  logic              vld_p0;
  logic              head_src_p0;
  logic [TAG_W-1:0]  head_tag_p0;
  logic [DATA_W-1:0] head_dat_p0;

  // ---- stage p0: arbitration on pre-edge occupancy, push/pop qualification
  // Decide grant, accepted pushes, dropped pushes and next occupancy.
  always_comb begin
    in_tag_p0[0] = alu_des;
    in_dat_p0[0] = alu_data;
    in_tag_p0[1] = mem_des;
    in_dat_p0[1] = mem_data;

    not_empty = '0;
    full      = '0;
    for (int s = 0; s < 2; s++) begin
      not_empty[s] = (cnt[s] != '0);
      full[s]      = (cnt[s] == FULL_CNT);
    end

    grant    = '0;
    grant[0] = not_empty[0] & (~not_empty[1] | last_grant);
    grant[1] = not_empty[1] & (~not_empty[0] | ~last_grant);

    push_req = '0;
    push     = '0;
    drop     = '0;
    for (int s = 0; s < 2; s++) begin
      push_req[s] = (in_tag_p0[s] != '0);
      // A full FIFO still accepts a push when its head leaves on the same edge.
      push[s]     = push_req[s] & ~flush & (~full[s] | grant[s]);
      drop[s]     = push_req[s] & ~flush & full[s] & ~grant[s];
      cnt_nxt[s]  = cnt[s] + CNT_W'(push[s]) - CNT_W'(grant[s]);
    end

    vld_p0      = |grant;
    head_src_p0 = grant[1];
    if (grant[1]) begin
      head_tag_p0 = tag_mem[1][rptr[1]];
      head_dat_p0 = dat_mem[1][rptr[1]];
    end else begin
      head_tag_p0 = tag_mem[0][rptr[0]];
      head_dat_p0 = dat_mem[0][rptr[0]];
    end
  end

  // FIFO pointers and occupancy; flush empties both queues.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < 2; s++) begin
        wptr[s] <= '0;
        rptr[s] <= '0;
        cnt[s]  <= '0;
      end
    end else if (flush) begin
      for (int s = 0; s < 2; s++) begin
        wptr[s] <= '0;
        rptr[s] <= '0;
        cnt[s]  <= '0;
      end
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (push[s]) begin
          wptr[s] <= wptr[s] + PTR_W'(1);
        end
        if (grant[s]) begin
          rptr[s] <= rptr[s] + PTR_W'(1);
        end
        cnt[s] <= cnt_nxt[s];
      end
    end
  end

  // Entry storage; data only, so no reset.
  always_ff @(posedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (push[s]) begin
        tag_mem[s][wptr[s]] <= in_tag_p0[s];
        dat_mem[s][wptr[s]] <= in_dat_p0[s];
      end
    end
  end

  // Registered stall derived from the post-edge occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_stall <= 1'b0;
      mem_stall <= 1'b0;
    end else if (flush) begin
      alu_stall <= 1'b0;
      mem_stall <= 1'b0;
    end else begin
      alu_stall <= (cnt_nxt[0] >= STALL_CNT);
      mem_stall <= (cnt_nxt[1] >= STALL_CNT);
    end
  end

  // Round-robin history; only moves when a grant is actually issued.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant <= 1'b1;
    end else if (flush) begin
      last_grant <= 1'b1;
    end else if (grant[0]) begin
      last_grant <= 1'b0;
    end else if (grant[1]) begin
      last_grant <= 1'b1;
    end
  end

  // Sticky overflow; survives flush, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow <= 1'b0;
    end else if (|drop) begin
      overflow <= 1'b1;
    end
  end

  // ---- stage p1: registered broadcast slot
  // Load the granted head onto the bus; tag returns to 0 when idle, data/src hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cdb_des  <= '0;
      cdb_data <= '0;
      cdb_src  <= 1'b0;
    end else if (flush) begin
      cdb_des <= '0;
    end else if (vld_p0) begin
      cdb_des  <= head_tag_p0;
      cdb_data <= head_dat_p0;
      cdb_src  <= head_src_p0;
    end else begin
      cdb_des <= '0;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: per-source scoreboard queues filled at
// drive time and drained on every broadcast, plus directed order/flag checks.
module tb_cdb_arbiter;

  localparam int DEPTH  = 4;
  localparam int TAG_W  = 3;
  localparam int DATA_W = 32;

  logic              clk      = 1'b0;
  logic              rst      = 1'b0;
  logic              flush    = 1'b0;
  logic [TAG_W-1:0]  alu_des  = '0;
  logic [DATA_W-1:0] alu_data = '0;
  logic [TAG_W-1:0]  mem_des  = '0;
  logic [DATA_W-1:0] mem_data = '0;
  logic              alu_stall;
  logic              mem_stall;
  logic [TAG_W-1:0]  cdb_des;
  logic [DATA_W-1:0] cdb_data;
  logic              cdb_src;
  logic              overflow;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } exp_t;

  exp_t q_alu[$];
  exp_t q_mem[$];

  int n_checks = 0;
  int n_errors = 0;

  cdb_arbiter #(
    .DEPTH (DEPTH),
    .TAG_W (TAG_W),
    .DATA_W(DATA_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .alu_des  (alu_des),
    .alu_data (alu_data),
    .mem_des  (mem_des),
    .mem_data (mem_data),
    .alu_stall(alu_stall),
    .mem_stall(mem_stall),
    .cdb_des  (cdb_des),
    .cdb_data (cdb_data),
    .cdb_src  (cdb_src),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within the time limit");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Compare any live broadcast against the head of its source's queue.
  task automatic sb_sample();
    exp_t e;
    if (rst && cdb_des != '0) begin
      if (cdb_src == 1'b0) begin
        if (q_alu.size() == 0) begin
          check("sb_alu_unexpected", 32'(cdb_des), 32'd0);
        end else begin
          e = q_alu.pop_front();
          check("sb_alu_tag", 32'(cdb_des), 32'(e.tag));
          check("sb_alu_data", cdb_data, e.data);
        end
      end else begin
        if (q_mem.size() == 0) begin
          check("sb_mem_unexpected", 32'(cdb_des), 32'd0);
        end else begin
          e = q_mem.pop_front();
          check("sb_mem_tag", 32'(cdb_des), 32'(e.tag));
          check("sb_mem_data", cdb_data, e.data);
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    sb_sample();
  endtask

  // Present one cycle of results; m_ok=0 marks a memory push that must be dropped.
  task automatic drive(input logic [TAG_W-1:0] at, input logic [31:0] ad,
                       input logic [TAG_W-1:0] mt, input logic [31:0] md,
                       input bit m_ok);
    alu_des  = at;
    alu_data = ad;
    mem_des  = mt;
    mem_data = md;
    if (at != '0) q_alu.push_back({at, ad});
    if (mt != '0 && m_ok) q_mem.push_back({mt, md});
    step();
    alu_des = '0;
    mem_des = '0;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_cdb_des", 32'(cdb_des), 32'd0);
    check("rst_cdb_data", cdb_data, 32'd0);
    check("rst_cdb_src", 32'(cdb_src), 32'd0);
    check("rst_alu_stall", 32'(alu_stall), 32'd0);
    check("rst_mem_stall", 32'(mem_stall), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    rst = 1'b1;

    // Tie round-robin: expect 1(A) 4(M) 2(A) 5(M) back to back
    drive(3'd1, 32'h1111_0001, 3'd4, 32'h4444_0004, 1'b1);
    check("tie_e1_des", 32'(cdb_des), 32'd0);
    drive(3'd2, 32'h1111_0002, 3'd5, 32'h4444_0005, 1'b1);
    check("tie_1_des", 32'(cdb_des), 32'd1);
    check("tie_1_src", 32'(cdb_src), 32'd0);
    step();
    check("tie_2_des", 32'(cdb_des), 32'd4);
    check("tie_2_src", 32'(cdb_src), 32'd1);
    step();
    check("tie_3_des", 32'(cdb_des), 32'd2);
    check("tie_3_src", 32'(cdb_src), 32'd0);
    step();
    check("tie_4_des", 32'(cdb_des), 32'd5);
    check("tie_4_src", 32'(cdb_src), 32'd1);
    step();
    check("tie_idle_des", 32'(cdb_des), 32'd0);

    // Back-pressure and overflow on the memory FIFO while the ALU splits grants
    drive(3'd1, 32'hA000_0001, 3'd1, 32'hB000_0001, 1'b1);
    check("bp_e1_mem_stall", 32'(mem_stall), 32'd0);
    drive(3'd2, 32'hA000_0002, 3'd2, 32'hB000_0002, 1'b1);
    check("bp_e2_des", 32'(cdb_des), 32'd1);
    check("bp_e2_src", 32'(cdb_src), 32'd0);
    check("bp_e2_mem_stall", 32'(mem_stall), 32'd0);
    drive(3'd3, 32'hA000_0003, 3'd3, 32'hB000_0003, 1'b1);
    check("bp_e3_src", 32'(cdb_src), 32'd1);
    check("bp_e3_mem_stall", 32'(mem_stall), 32'd0);
    drive(3'd4, 32'hA000_0004, 3'd4, 32'hB000_0004, 1'b1);
    check("bp_e4_mem_stall", 32'(mem_stall), 32'd1);
    check("bp_e4_alu_stall", 32'(alu_stall), 32'd0);
    check("bp_e4_overflow", 32'(overflow), 32'd0);
    drive(3'd0, 32'h0, 3'd5, 32'hB000_0005, 1'b1);
    check("bp_e5_des", 32'(cdb_des), 32'd2);
    check("bp_e5_src", 32'(cdb_src), 32'd1);
    drive(3'd0, 32'h0, 3'd6, 32'hB000_0006, 1'b1);
    check("bp_e6_src", 32'(cdb_src), 32'd0);
    check("bp_e6_mem_stall", 32'(mem_stall), 32'd1);
    drive(3'd0, 32'h0, 3'd7, 32'hB000_0007, 1'b1);
    check("full_push_pop_overflow", 32'(overflow), 32'd0);
    drive(3'd0, 32'h0, 3'd6, 32'hBAD0_0008, 1'b0);
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_e8_des", 32'(cdb_des), 32'd4);
    step();
    check("drain_e9_mem_stall", 32'(mem_stall), 32'd1);
    step();
    check("drain_e10_mem_stall", 32'(mem_stall), 32'd0);
    step();
    step();
    check("drain_last_des", 32'(cdb_des), 32'd7);
    step();
    check("drain_idle_des", 32'(cdb_des), 32'd0);
    check("ovf_sticky", 32'(overflow), 32'd1);

    // Flush with queued entries and a same-edge ALU push of tag 6
    drive(3'd1, 32'hC000_0001, 3'd1, 32'hD000_0001, 1'b1);
    drive(3'd2, 32'hC000_0002, 3'd2, 32'hD000_0002, 1'b1);
    drive(3'd0, 32'h0, 3'd3, 32'hD000_0003, 1'b1);
    drive(3'd0, 32'h0, 3'd4, 32'hD000_0004, 1'b1);
    check("fl_pre_mem_stall", 32'(mem_stall), 32'd1);
    flush    = 1'b1;
    alu_des  = 3'd6;
    alu_data = 32'hC000_0066;
    step();
    flush   = 1'b0;
    alu_des = '0;
    q_alu.delete();
    q_mem.delete();
    check("fl_cdb_des", 32'(cdb_des), 32'd0);
    check("fl_alu_stall", 32'(alu_stall), 32'd0);
    check("fl_mem_stall", 32'(mem_stall), 32'd0);
    check("fl_overflow_kept", 32'(overflow), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("fl_idle_des", 32'(cdb_des), 32'd0);
    end
    drive(3'd5, 32'hE000_0005, 3'd3, 32'hF000_0003, 1'b1);
    step();
    check("fl_tie_1_des", 32'(cdb_des), 32'd5);
    check("fl_tie_1_src", 32'(cdb_src), 32'd0);
    step();
    check("fl_tie_2_des", 32'(cdb_des), 32'd3);
    check("fl_tie_2_src", 32'(cdb_src), 32'd1);
    step();

    // Single-source minimum latency
    drive(3'd3, 32'hDEAD_BEEF, 3'd0, 32'h0, 1'b1);
    check("lat_k_des", 32'(cdb_des), 32'd0);
    step();
    check("lat_k1_des", 32'(cdb_des), 32'd3);
    check("lat_k1_data", cdb_data, 32'hDEAD_BEEF);
    check("lat_k1_src", 32'(cdb_src), 32'd0);
    step();
    check("lat_k2_des", 32'(cdb_des), 32'd0);

    // Asynchronous reset while both FIFOs hold two entries
    drive(3'd1, 32'h5000_0001, 3'd2, 32'h6000_0002, 1'b1);
    drive(3'd2, 32'h5000_0002, 3'd3, 32'h6000_0003, 1'b1);
    drive(3'd3, 32'h5000_0003, 3'd4, 32'h6000_0004, 1'b1);
    #2;
    rst = 1'b0;
    q_alu.delete();
    q_mem.delete();
    #1;
    check("mid_rst_cdb_des", 32'(cdb_des), 32'd0);
    check("mid_rst_cdb_data", cdb_data, 32'd0);
    check("mid_rst_cdb_src", 32'(cdb_src), 32'd0);
    check("mid_rst_alu_stall", 32'(alu_stall), 32'd0);
    check("mid_rst_mem_stall", 32'(mem_stall), 32'd0);
    check("mid_rst_overflow", 32'(overflow), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("post_rst_idle_des", 32'(cdb_des), 32'd0);
    end
    drive(3'd2, 32'h7000_0002, 3'd6, 32'h8000_0006, 1'b1);
    step();
    check("post_rst_1_des", 32'(cdb_des), 32'd2);
    check("post_rst_1_src", 32'(cdb_src), 32'd0);
    step();
    check("post_rst_2_des", 32'(cdb_des), 32'd6);
    check("post_rst_2_src", 32'(cdb_src), 32'd1);
    step();
    check("post_rst_idle", 32'(cdb_des), 32'd0);

    check("sb_alu_left", 32'(q_alu.size()), 32'd0);
    check("sb_mem_left", 32'(q_mem.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Shares one common-data-bus (CDB) broadcast slot between the two result producers, the ALU and the memory unit. Each producer pushes tagged results into its own small FIFO. A round-robin arbiter drains the heads onto a single registered broadcast bus. That bus drives the reservation station's wake-up/forwarding inputs and the reorder logic. The block applies stall back-pressure to each producer and supports a full flush on branch mispredict.

## Interface
- DEPTH, 4: entries per source FIFO; power of two, at least 2.
- TAG_W, 3: destination tag width. Tag 0 means "no result".
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous; discard all queued and in-flight results.
- alu_des  in  TAG_W  ALU result tag; nonzero means a result is present this cycle.
- alu_data  in  32  ALU result value.
- mem_des  in  TAG_W  memory-unit result tag; nonzero means a result is present.
- mem_data  in  32  memory-unit result value.
- alu_stall  out  1  registered; ALU must not present a new result while high.
- mem_stall  out  1  registered; memory unit must not present a new result while high.
- cdb_des  out  TAG_W  broadcast tag; 0 means idle.
- cdb_data  out  32  broadcast value; holds its last value when idle.
- cdb_src  out  1  source of the current broadcast: 0 = ALU, 1 = memory.
- overflow  out  1  sticky; set when a push arrives at a full FIFO.

## Operation
- Each source has a DEPTH-entry circular FIFO holding {tag, data}.
  - Read and write pointers are log2(DEPTH) bits and wrap naturally.
  - Occupancy count is log2(DEPTH)+1 bits.
- Push: on an edge where the source's des ≠ 0, {des, data} is written at wptr.
  - If count == DEPTH and no pop of that FIFO occurs on the same edge, the push is dropped and overflow is set.
  - A push to a full FIFO with a simultaneous pop succeeds.
- Arbitration uses occupancy before the edge.
  - If both FIFOs are non-empty, grant the source not granted last (last_grant register).
  - If only one is non-empty, grant it; last_grant updates only when a grant occurs.
  - On a grant: the head entry is popped and loaded into cdb_des/cdb_data/cdb_src.
  - With no grant: cdb_des ← 0, cdb_src holds, cdb_data holds.
- Stall: after each edge, x_stall = (new count_x ≥ DEPTH−1). This leaves one slot of slack for a result already launched when stall rises.
- Flush (rst high, flush=1): both FIFOs empty (pointers and counts 0), cdb_des ← 0, both stalls ← 0, last_grant ← memory.
  - Pushes on the flush edge are discarded.
  - overflow is not cleared by flush.
- Reset (rst=0, asynchronous): FIFOs empty, cdb_des=0, cdb_data=0, cdb_src=0, alu_stall=0, mem_stall=0, overflow=0, last_grant=memory (ALU wins the first tie).

## Timing
- Minimum latency: a result sampled at edge k into an empty FIFO appears on the CDB after edge k+1.
  - Push and pop of the same entry never occur on one edge; there is no bypass.
- Throughput: one broadcast per cycle total. Under sustained contention each source gets every other cycle.
- cdb_des is nonzero for exactly one cycle per result. Consumers sample it on the following edge.
- Stall timing:
  - Stall is registered. A producer sees stall one cycle after the push that raised it.
  - That cycle may still carry one push, which fits in the reserved slot.
- Reset deassertion is synchronised externally. The first possible push is on the first edge after rst rises.

## Test plan
- Reset/idle:
  - Stimulus: assert rst=0 mid-run while both FIFOs hold 2 entries.
  - Required: all outputs immediately 0. After release with no inputs, cdb_des stays 0.
- Single-source latency:
  - Stimulus: ALU pushes tag 3, data 0xDEADBEEF at edge k.
  - Required: cdb_des=3, cdb_data=0xDEADBEEF, cdb_src=0 after edge k+1; cdb_des=0 after edge k+2.
- Tie round-robin:
  - Stimulus: same edge, ALU pushes tags 1,2 and memory pushes tags 4,5 on consecutive edges.
  - Required: broadcast order 1(ALU), 4(mem), 2(ALU), 5(mem), no idle gaps.
- Back-pressure:
  - Stimulus: memory pushes 4 results on consecutive edges while the ALU queue keeps the grant split.
  - Required: mem_stall rises after count reaches 3. The 4th push is accepted, overflow stays 0, and all 4 tags broadcast in order.
- Overflow:
  - Stimulus: ignore stall and push a 5th result into a full FIFO on an edge with no memory grant.
  - Required: overflow=1 and sticky; that tag is never broadcast.
- Flush:
  - Stimulus: with 3 entries queued, assert flush together with an ALU push of tag 6.
  - Required: after the edge, cdb_des=0, stalls=0, and no tag including 6 is ever broadcast. The next push broadcasts normally with ALU winning the first tie.
